median9_sequencer: RTL

Time-multiplexed median-of-9 engine for the median filter: accepts one 3x3 window of 8-bit pixels, runs the fixed 19-step compare-exchange network through a single shared `comparison` instance, and returns the median. It sits between the window generator (upstream, valid/ready) and the output pixel stage (downstream, valid/ready). It trades throughput (one result per 40 cycles) for area: one comparator instead of nineteen.

---
 rtl/median_pkg.sv | 25 ++
 rtl/comparison.sv | 33 +++
 rtl/median9_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/median_pkg.sv
// Shared definitions for the median-of-9 engine.
//   state_e          : sequencer states
//   NUM_PIX          : pixels per 3x3 window
//   NUM_STEPS        : length of the compare-exchange network
//   MEDIAN_IDX       : register that holds the median once the network completes
//   SCHED_A/SCHED_B  : per-step register pair; the smaller value lands in SCHED_A
package median_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WB, DONE} state_e;

  localparam int NUM_PIX    = 9;
  localparam int NUM_STEPS  = 19;
  localparam int MEDIAN_IDX = 4;

  localparam logic [3:0] SCHED_A [NUM_STEPS] = '{
    4'd1, 4'd4, 4'd7, 4'd0, 4'd3, 4'd6, 4'd1, 4'd4, 4'd7, 4'd0,
    4'd5, 4'd4, 4'd3, 4'd1, 4'd2, 4'd4, 4'd4, 4'd6, 4'd4
  };

  localparam logic [3:0] SCHED_B [NUM_STEPS] = '{
    4'd2, 4'd5, 4'd8, 4'd1, 4'd4, 4'd7, 4'd2, 4'd5, 4'd8, 4'd3,
    4'd8, 4'd7, 4'd6, 4'd4, 4'd5, 4'd7, 4'd2, 4'd4, 4'd2
  };

endpackage

// File: rtl/comparison.sv
// Registered 8-bit compare-exchange cell. No reset; captures every cycle.
//   iClk          : clock
//   iNum1, iNum2  : operands
//   oNum_Smaller  : min(iNum1, iNum2) one cycle later (iNum1 on a tie)
//   oNum_Greater  : max(iNum1, iNum2) one cycle later
module comparison (
  input  logic       iClk,
  input  logic [7:0] iNum1,
  input  logic [7:0] iNum2,
  output logic [7:0] oNum_Smaller,
  output logic [7:0] oNum_Greater
);

  logic [7:0] lo_q, lo_d, hi_q, hi_d;

  always_comb begin
    lo_d = iNum1;
    hi_d = iNum2;
    if (iNum2 < iNum1) begin
      lo_d = iNum2;
      hi_d = iNum1;
    end
  end

  always_ff @(posedge iClk) begin
    lo_q <= lo_d;
    hi_q <= hi_d;
  end

  assign oNum_Smaller = lo_q;
  assign oNum_Greater = hi_q;

endmodule

// File: rtl/median9_sequencer.sv
// Time-multiplexed median-of-9: loads a 3x3 window, walks the 19-step
// compare-exchange network through one shared comparison cell (2 cycles per
// step), then presents the median until downstream accepts it.
//   iClk, iRst_n      : clock, synchronous active-low reset
//   iWindow           : p0..p8, pixel i at [8i+7:8i]
//   iValid / oReady   : upstream handshake (accept in IDLE only)
//   oMedian / oValid  : registered result, held until iReady
//   iReady            : downstream accept
//   oBusy             : high while the network is running
module median9_sequencer
  import median_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic [9*DATA_W-1:0]   iWindow,
  input  logic                  iValid,
  output logic                  oReady,
  output logic [DATA_W-1:0]     oMedian,
  output logic                  oValid,
  input  logic                  iReady,
  output logic                  oBusy
);

  state_e                          state_q, state_d;
  logic [4:0]                      step_q, step_d;
  logic [NUM_PIX-1:0][DATA_W-1:0]  r_q, r_d;
  logic [DATA_W-1:0]               med_q, med_d;
  logic                            rdy_q, rdy_d;
  logic                            vld_q, vld_d;
  logic                            busy_q, busy_d;

  logic [3:0]        idx_a, idx_b;
  logic [DATA_W-1:0] cmp_lo, cmp_hi;
  logic              accept;

  assign idx_a = SCHED_A[step_q];
  assign idx_b = SCHED_B[step_q];

  // Operands are driven unconditionally from the current step; the cell's
  // outputs are only consumed in WB, when they reflect the ISSUE cycle.
  comparison u_cmp (
    .iClk         (iClk),
    .iNum1        (r_q[idx_a]),
    .iNum2        (r_q[idx_b]),
    .oNum_Smaller (cmp_lo),
    .oNum_Greater (cmp_hi)
  );

  // Gating with the reset keeps oReady low while reset is held and lets it
  // rise in the first cycle after release.
  assign oReady  = rdy_q & iRst_n;
  assign accept  = iValid & oReady;
  assign oValid  = vld_q;
  assign oMedian = med_q;
  assign oBusy   = busy_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    r_d     = r_q;
    med_d   = med_q;
    rdy_d   = rdy_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          r_d     = iWindow;
          step_d  = '0;
          state_d = ISSUE;
          rdy_d   = 1'b0;
          busy_d  = 1'b1;
        end
      end
      ISSUE: state_d = WB;
      WB: begin
        r_d[idx_a] = cmp_lo;
        r_d[idx_b] = cmp_hi;
        if (step_q == 5'(NUM_STEPS - 1)) begin
          med_d   = r_d[MEDIAN_IDX];
          state_d = DONE;
          busy_d  = 1'b0;
          vld_d   = 1'b1;
        end else begin
          step_d  = step_q + 5'd1;
          state_d = ISSUE;
        end
      end
      DONE: begin
        if (iReady) begin
          state_d = IDLE;
          vld_d   = 1'b0;
          rdy_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      step_q  <= '0;
      med_q   <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      med_q   <= med_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  // Register file contents are meaningless after reset; no reset needed.
  always_ff @(posedge iClk) begin
    r_q <= r_d;
  end

endmodule
